// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: controller FSM states, per-latch freeze/flush pair,
// register index type.
package cpu_types_pkg;

    localparam int unsigned REGBITS_W = 5;

    typedef logic [REGBITS_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        HALTED
    } pipe_state_t;

    typedef struct packed {
        logic freeze;
        logic flush;
    } latch_ctrl_t;

    localparam latch_ctrl_t LC_PASS   = '{freeze: 1'b0, flush: 1'b0};
    localparam latch_ctrl_t LC_HOLD   = '{freeze: 1'b1, flush: 1'b0};
    localparam latch_ctrl_t LC_BUBBLE = '{freeze: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/sequencing bundle between the pipeline datapath and pipe_ctrl.
// master = controller side, slave = datapath side.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned REG_W = 5
) ();

    logic             ihit;
    logic             dhit;
    logic [REG_W-1:0] fd_rs;
    logic [REG_W-1:0] fd_rt;
    logic             dx_dREN;
    logic [REG_W-1:0] dx_wsel;
    logic             xm_dREN;
    logic             xm_dWEN;
    logic             branch_taken;
    logic             jump;
    logic             mw_halt;

    logic             pc_en;
    logic             fd_freeze;
    logic             dx_freeze;
    logic             xm_freeze;
    logic             mw_freeze;
    logic             fd_flush;
    logic             dx_flush;
    logic             xm_flush;
    logic             mw_flush;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  ihit, dhit, fd_rs, fd_rt, dx_dREN, dx_wsel,
               xm_dREN, xm_dWEN, branch_taken, jump, mw_halt,
        output pc_en, fd_freeze, dx_freeze, xm_freeze, mw_freeze,
               fd_flush, dx_flush, xm_flush, mw_flush,
               halt_out, stall_cnt, flush_cnt
    );

    modport slave (
        output ihit, dhit, fd_rs, fd_rt, dx_dREN, dx_wsel,
               xm_dREN, xm_dWEN, branch_taken, jump, mw_halt,
        input  pc_en, fd_freeze, dx_freeze, xm_freeze, mw_freeze,
               fd_flush, dx_flush, xm_flush, mw_flush,
               halt_out, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in execute whose destination feeds the
// instruction in decode. Register 0 is never a real dependency.
module hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             dx_dREN,
    input  logic [REG_W-1:0] dx_wsel,
    output logic             lu_hazard
);

    always_comb begin
        lu_hazard = dx_dREN && (dx_wsel != '0) &&
                    ((dx_wsel == fd_rs) || (dx_wsel == fd_rt));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: per-latch freeze/flush and PC enable,
// data-memory wait / halt FSM, saturating stall and redirect counters.
module pipe_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned REG_W = 5
) (
    input  logic         CLK,
    input  logic         RST,
    pipe_ctrl_if.master  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_t      state;
    logic             halt_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic        lu_hazard;
    logic        pending;
    logic        halting;
    logic        mem_stall;
    logic        redirect;
    logic        redirect_act;
    logic        pc_en;
    latch_ctrl_t fd_c, dx_c, xm_c, mw_c;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .fd_rs     (bus.fd_rs),
        .fd_rt     (bus.fd_rt),
        .dx_dREN   (bus.dx_dREN),
        .dx_wsel   (bus.dx_wsel),
        .lu_hazard (lu_hazard)
    );

    always_comb begin
        pending   = bus.xm_dREN || bus.xm_dWEN;
        halting   = (state == HALTED) || bus.mw_halt;
        // A DWAIT cycle that sees dhit is already the advancing cycle.
        mem_stall = !bus.dhit && ((state == DWAIT) || pending);
        redirect  = bus.branch_taken || bus.jump;
    end

    always_comb begin
        pc_en        = 1'b1;
        fd_c         = LC_PASS;
        dx_c         = LC_PASS;
        xm_c         = LC_PASS;
        mw_c         = LC_PASS;
        redirect_act = 1'b0;
        if (RST) begin
            pc_en = 1'b0;
            fd_c  = LC_BUBBLE;
            dx_c  = LC_BUBBLE;
            xm_c  = LC_BUBBLE;
            mw_c  = LC_BUBBLE;
        end else if (halting) begin
            pc_en = 1'b0;
            fd_c  = LC_HOLD;
            dx_c  = LC_HOLD;
            xm_c  = LC_HOLD;
            mw_c  = LC_HOLD;
        end else if (mem_stall) begin
            pc_en = 1'b0;
            fd_c  = LC_HOLD;
            dx_c  = LC_HOLD;
            xm_c  = LC_HOLD;
            mw_c  = LC_BUBBLE;
        end else if (redirect) begin
            // Redirect squashes the dependent instruction, so it beats load-use
            // and a fetch miss (the missed word is discarded by fd_flush).
            redirect_act = 1'b1;
            fd_c         = LC_BUBBLE;
            dx_c         = LC_BUBBLE;
        end else if (lu_hazard) begin
            pc_en = 1'b0;
            fd_c  = LC_HOLD;
            dx_c  = LC_BUBBLE;
        end else if (!bus.ihit) begin
            pc_en = 1'b0;
            fd_c  = LC_BUBBLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= RUN;
            halt_q <= 1'b0;
        end else begin
            halt_q <= halting;
            unique case (state)
                RUN: begin
                    if (bus.mw_halt)
                        state <= HALTED;
                    else if (pending && !bus.dhit)
                        state <= DWAIT;
                end
                DWAIT: begin
                    if (bus.mw_halt)
                        state <= HALTED;
                    else if (bus.dhit)
                        state <= RUN;
                end
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (state != HALTED) && (stall_q != '1))
                stall_q <= stall_q + CNT_ONE;
            if (redirect_act && (flush_q != '1))
                flush_q <= flush_q + CNT_ONE;
        end
    end

    always_comb begin
        bus.pc_en     = pc_en;
        bus.fd_freeze = fd_c.freeze;
        bus.fd_flush  = fd_c.flush;
        bus.dx_freeze = dx_c.freeze;
        bus.dx_flush  = dx_c.flush;
        bus.xm_freeze = xm_c.freeze;
        bus.xm_flush  = xm_c.flush;
        bus.mw_freeze = mw_c.freeze;
        bus.mw_flush  = mw_c.flush;
        bus.halt_out  = halt_q;
        bus.stall_cnt = stall_q;
        bus.flush_cnt = flush_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table plus multi-cycle sequences,
// and a narrow-counter instance for saturation.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_sat = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(16), .REG_W(5)) bus ();
    pipe_ctrl_if #(.CNT_W(4),  .REG_W(5)) sat_bus ();

    pipe_ctrl #(.CNT_W(16), .REG_W(5)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    pipe_ctrl #(.CNT_W(4), .REG_W(5)) u_sat (
        .CLK (clk),
        .RST (rst_sat),
        .bus (sat_bus)
    );

    // Expected control word: {pc_en, fd/dx/xm/mw freeze, fd/dx/xm/mw flush}
    localparam logic [8:0] C_NORM  = 9'b1_0000_0000;
    localparam logic [8:0] C_RST   = 9'b0_0000_1111;
    localparam logic [8:0] C_HALT  = 9'b0_1111_0000;
    localparam logic [8:0] C_MEM   = 9'b0_1110_0001;
    localparam logic [8:0] C_REDIR = 9'b1_0000_1100;
    localparam logic [8:0] C_LU    = 9'b0_1000_0100;
    localparam logic [8:0] C_MISS  = 9'b0_0000_1000;

    typedef struct {
        string      name;
        logic       rst;
        logic       ihit;
        logic       dhit;
        logic [4:0] fd_rs;
        logic [4:0] fd_rt;
        logic       dx_dren;
        logic [4:0] dx_wsel;
        logic       xm_dren;
        logic       xm_dwen;
        logic       br;
        logic       jmp;
        logic       mw_halt;
        logic [9:0] exp;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [9:0] exp_q[$];
    string      name_q[$];
    vec_t       tbl[$];

    function automatic vec_t mk(string name, logic r, logic ih, logic dh,
                                logic [4:0] rs, logic [4:0] rt, logic dren,
                                logic [4:0] wsel, logic xr, logic xw, logic br,
                                logic jmp, logic mh, logic eh, logic [8:0] ec);
        vec_t v;
        v.name = name; v.rst = r; v.ihit = ih; v.dhit = dh;
        v.fd_rs = rs; v.fd_rt = rt; v.dx_dren = dren; v.dx_wsel = wsel;
        v.xm_dren = xr; v.xm_dwen = xw; v.br = br; v.jmp = jmp; v.mw_halt = mh;
        v.exp = {eh, ec};
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic sample();
        logic [9:0] act;
        logic [9:0] exp;
        string      nm;
        act = {bus.halt_out, bus.pc_en,
               bus.fd_freeze, bus.dx_freeze, bus.xm_freeze, bus.mw_freeze,
               bus.fd_flush, bus.dx_flush, bus.xm_flush, bus.mw_flush};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got output %b expected a queued entry", act);
        end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            check(nm, {6'b0, act}, {6'b0, exp});
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst              = v.rst;
        bus.ihit         = v.ihit;
        bus.dhit         = v.dhit;
        bus.fd_rs        = v.fd_rs;
        bus.fd_rt        = v.fd_rt;
        bus.dx_dREN      = v.dx_dren;
        bus.dx_wsel      = v.dx_wsel;
        bus.xm_dREN      = v.xm_dren;
        bus.xm_dWEN      = v.xm_dwen;
        bus.branch_taken = v.br;
        bus.jump         = v.jmp;
        bus.mw_halt      = v.mw_halt;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        #5;
        sample();
    endtask

    task automatic chk_cnt(input string tag, input int unsigned es, input int unsigned ef,
                           input logic eh);
        @(posedge clk);
        #1;
        check({tag, "_stall_cnt"}, bus.stall_cnt, es[15:0]);
        check({tag, "_flush_cnt"}, bus.flush_cnt, ef[15:0]);
        check({tag, "_halt_out"}, {15'b0, bus.halt_out}, {15'b0, eh});
    endtask

    task automatic run_all();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        bus.ihit = 1'b0; bus.dhit = 1'b0; bus.fd_rs = '0; bus.fd_rt = '0;
        bus.dx_dREN = 1'b0; bus.dx_wsel = '0; bus.xm_dREN = 1'b0; bus.xm_dWEN = 1'b0;
        bus.branch_taken = 1'b0; bus.jump = 1'b0; bus.mw_halt = 1'b0;
        sat_bus.ihit = 1'b0; sat_bus.dhit = 1'b0; sat_bus.fd_rs = '0; sat_bus.fd_rt = '0;
        sat_bus.dx_dREN = 1'b0; sat_bus.dx_wsel = '0; sat_bus.xm_dREN = 1'b0;
        sat_bus.xm_dWEN = 1'b0; sat_bus.branch_taken = 1'b0; sat_bus.jump = 1'b0;
        sat_bus.mw_halt = 1'b0;

        // Priority table, executed in order from reset (state-carrying rows noted).
        //            name          rst ih dh rs  rt  ld wsel xr xw br j  mh  h  ctrl
        tbl.push_back(mk("rst0",      1, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_RST));
        tbl.push_back(mk("rst1",      1, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_RST));
        tbl.push_back(mk("normal",    0, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_NORM));
        tbl.push_back(mk("fetch_miss",0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_MISS));
        tbl.push_back(mk("lu_rs",     0, 1, 0, 8,  2,  1, 8,   0, 0, 0, 0, 0, 0, C_LU));
        tbl.push_back(mk("lu_after",  0, 1, 0, 8,  2,  0, 8,   0, 0, 0, 0, 0, 0, C_NORM));
        tbl.push_back(mk("lu_rt",     0, 1, 0, 1,  3,  1, 3,   0, 0, 0, 0, 0, 0, C_LU));
        tbl.push_back(mk("lu_r0",     0, 1, 0, 0,  0,  1, 0,   0, 0, 0, 0, 0, 0, C_NORM));
        tbl.push_back(mk("lu_nomatch",0, 1, 0, 7,  9,  1, 8,   0, 0, 0, 0, 0, 0, C_NORM));
        tbl.push_back(mk("jump",      0, 1, 0, 0,  0,  0, 0,   0, 0, 0, 1, 0, 0, C_REDIR));
        tbl.push_back(mk("br_lu_miss",0, 0, 0, 8,  0,  1, 8,   0, 0, 1, 0, 0, 0, C_REDIR));
        tbl.push_back(mk("store_hit", 0, 1, 1, 0,  0,  0, 0,   0, 1, 0, 0, 0, 0, C_NORM));
        tbl.push_back(mk("load_miss", 0, 1, 0, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0, C_MEM));
        tbl.push_back(mk("dwait_br",  0, 1, 0, 0,  0,  0, 0,   1, 0, 1, 0, 0, 0, C_MEM));
        tbl.push_back(mk("dwait_hit", 0, 1, 1, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0, C_NORM));
        tbl.push_back(mk("store_miss",0, 0, 0, 0,  0,  0, 0,   0, 1, 0, 0, 0, 0, C_MEM));
        tbl.push_back(mk("dhit_imiss",0, 0, 1, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_MISS));
        tbl.push_back(mk("normal2",   0, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_NORM));
        run_all();
        chk_cnt("table", 7, 2, 1'b0);

        // Reset asserted while in DWAIT must abort back to RUN with cleared counters.
        tbl.push_back(mk("pre_dwait", 0, 1, 0, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0, C_MEM));
        tbl.push_back(mk("rst_dw0",   1, 1, 0, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0, C_RST));
        tbl.push_back(mk("rst_dw1",   1, 1, 0, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0, C_RST));
        tbl.push_back(mk("post_rst",  0, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_NORM));
        run_all();
        chk_cnt("reset", 0, 0, 1'b0);

        // Three-cycle data wait, branch injected mid-wait.
        tbl.push_back(mk("rst_w0",    1, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_RST));
        tbl.push_back(mk("rst_w1",    1, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_RST));
        tbl.push_back(mk("wait1",     0, 1, 0, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0, C_MEM));
        tbl.push_back(mk("wait2_br",  0, 1, 0, 0,  0,  0, 0,   1, 0, 1, 0, 0, 0, C_MEM));
        tbl.push_back(mk("wait3",     0, 1, 0, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0, C_MEM));
        tbl.push_back(mk("wait_hit",  0, 1, 1, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0, C_NORM));
        run_all();
        chk_cnt("dwait", 3, 0, 1'b0);

        // Halt: one-cycle mw_halt, then sticky regardless of other inputs.
        tbl.push_back(mk("rst_h0",    1, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_RST));
        tbl.push_back(mk("rst_h1",    1, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_RST));
        tbl.push_back(mk("halt_req",  0, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 1, 0, C_HALT));
        tbl.push_back(mk("halted1",   0, 0, 0, 0,  0,  0, 0,   1, 0, 0, 0, 0, 1, C_HALT));
        tbl.push_back(mk("halted2",   0, 1, 1, 0,  0,  0, 0,   0, 0, 1, 0, 0, 1, C_HALT));
        tbl.push_back(mk("halted3",   0, 0, 1, 8,  0,  1, 8,   0, 1, 0, 1, 0, 1, C_HALT));
        tbl.push_back(mk("halted4",   0, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 1, C_HALT));
        run_all();
        chk_cnt("halt", 1, 0, 1'b1);
        tbl.push_back(mk("rst_hx0",   1, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 1, C_RST));
        tbl.push_back(mk("rst_hx1",   1, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_RST));
        tbl.push_back(mk("unhalted",  0, 1, 0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0, C_NORM));
        run_all();
        chk_cnt("unhalt", 0, 0, 1'b0);

        // 4-bit counter instance: continuous fetch misses must stick at 15.
        @(posedge clk);
        #1;
        rst_sat = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("sat_count10", {12'b0, sat_bus.stall_cnt}, 16'd10);
        repeat (11) @(posedge clk);
        #1;
        check("sat_count21", {12'b0, sat_bus.stall_cnt}, 16'd15);
        check("sat_pc_en", {15'b0, sat_bus.pc_en}, 16'd0);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives freeze/flush for the four pipeline latches (fetch/decode, decode/execute, execute/mem, mem/writeback) and the PC enable.
- Decisions are based on cache hits, load-use hazards, resolved branches/jumps and halt.
- Holds a small FSM for data-memory waits and halt, plus saturating performance counters.

Parameters:
- CNT_W, 16, width of stall and flush performance counters.
- REG_W, 5, register index width.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous reset, active-high
- ihit  in  1  instruction cache returned the fetch word this cycle
- dhit  in  1  data cache completed the mem-stage request this cycle
- fd_rs  in  REG_W  rs field of the instruction in decode
- fd_rt  in  REG_W  rt field of the instruction in decode
- dx_dREN  in  1  instruction in execute is a load
- dx_wsel  in  REG_W  destination register of the instruction in execute
- xm_dREN  in  1  mem-stage load pending
- xm_dWEN  in  1  mem-stage store pending
- branch_taken  in  1  execute resolved a taken branch (mispredict, predict-not-taken)
- jump  in  1  execute resolved J/JAL/JR
- mw_halt  in  1  halt instruction reached writeback
- pc_en  out  1  PC update enable
- fd_freeze, dx_freeze, xm_freeze, mw_freeze  out  1 each  hold latch contents
- fd_flush, dx_flush, xm_flush, mw_flush  out  1 each  load bubble (all-zero, control flags cleared)
- halt_out  out  1  sticky processor halted
- stall_cnt  out  CNT_W  cycles with pc_en=0, excluding HALTED
- flush_cnt  out  CNT_W  branch/jump redirects

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is synchronous and active-high. All state updates on the rising edge of CLK.
- Control outputs are combinational from inputs and registered state. State, halt_out and counters are registered.
- Reset:
  - On the next edge: state=RUN, halt_out=0, stall_cnt=0, flush_cnt=0.
  - While RST is high: pc_en=0, all four flush=1, all four freeze=0.
  - RST mid-stall or while HALTED aborts to RUN.
- FSM states:
  - RUN -> DWAIT when (xm_dREN|xm_dWEN) & !dhit.
  - DWAIT -> RUN on dhit.
  - Any state -> HALTED when mw_halt=1. HALTED exits only by RST.
  - A request with dhit in the same cycle stays in RUN and causes no stall.
- Priority of control actions, highest first:
  1. HALTED or mw_halt: pc_en=0, all freeze=1, all flush=0, halt_out=1 from the next cycle.
  2. Mem stall (DWAIT, or RUN with pending request and !dhit): pc_en=0, fd/dx/xm_freeze=1, mw_flush=1. Any ihit this cycle is ignored; the fetch is re-issued.
  3. Redirect (branch_taken|jump): fd_flush=1, dx_flush=1, pc_en=1, xm/mw advance. Outranks load-use, since the dependent instruction is squashed.
  4. Load-use: dx_dREN & dx_wsel!=0 & (dx_wsel==fd_rs | dx_wsel==fd_rt): pc_en=0, fd_freeze=1, dx_flush=1. Exactly one bubble, because the next cycle dx_dREN=0.
  5. Fetch miss (!ihit): pc_en=0, fd_flush=1, later stages advance.
  6. Otherwise: pc_en=1, all freeze/flush=0.
- Exclusivity: freeze and flush of the same latch are never both 1.
- A redirect coincident with !ihit gives pc_en=1: the redirect target is loaded and the fetch-stage word is discarded via fd_flush.
- Counters:
  - stall_cnt increments each cycle pc_en=0 with state!=HALTED and RST=0.
  - flush_cnt increments each cycle rule 3 applies.
  - Both saturate at all-ones with no wrap.
- Latency: zero cycles from input to control output. One cycle from an event to state, halt_out or counter update.

Decomposition:
- Shared package cpu_types_pkg gets:
  - pipe_state_t enum {RUN, DWAIT, HALTED}
  - typedef latch_ctrl_t struct {freeze, flush}
  - regbits_t (REG_W) reused
- Optional sub-module hazard_detect: pure combinational load-use compare (fd_rs, fd_rt, dx_dREN, dx_wsel -> lu_hazard), reused by the forwarding unit.
- FSM and counters stay in pipe_ctrl.

Test Plan:
- Reset: hold RST 2 cycles mid-DWAIT -> pc_en=0, all flush=1, then state=RUN, counters=0, halt_out=0.
- Load-use: dx_dREN=1, dx_wsel=8, fd_rs=8, ihit=1 -> one cycle pc_en=0, fd_freeze=1, dx_flush=1; next cycle (dx_dREN=0) pc_en=1; stall_cnt=1. Repeat with dx_wsel=0 -> no stall.
- Data wait: xm_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of fd/dx/xm_freeze=1 and mw_flush=1; the dhit cycle advances; stall_cnt=3. Inject a branch_taken during the wait -> stall still wins, flush_cnt unchanged.
- Redirect vs load-use: branch_taken=1 with a load-use hazard and ihit=0 in the same cycle -> pc_en=1, fd_flush=dx_flush=1, no freeze; flush_cnt=1.
- Halt: mw_halt=1 for 1 cycle, then drop it and toggle ihit/dhit -> halt_out=1 from the next cycle, all freeze=1 persistently, stall_cnt frozen; RST clears it.
- Saturation: force 2^CNT_W+5 fetch-miss cycles (CNT_W=4 override) -> stall_cnt=15, no wrap.
